// File: rtl/lebug_cfg_pkg.sv
// Shared definitions for the instrumentation reconfiguration bus.
// Receivers import this too, so no real PERSONAL_CONFIG_ID ever equals NO_CONFIG_ID.
package lebug_cfg_pkg;

   localparam int CFG_ID_W   = 8;
   localparam int CFG_DATA_W = 8;

   localparam logic [CFG_ID_W-1:0] NO_CONFIG_ID = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      QUIESCE,
      LOAD,
      SETTLE
   } cfg_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cfg_down_counter.sv
// Loadable down counter that saturates at zero; load takes priority over decrement.
module cfg_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/config_loader.sv
// Reconfiguration sequencer: drops tracing, drains the pipeline, streams host
// (id, data) entries onto the config bus with a fixed hold, settles, resumes tracing.
module config_loader
   import lebug_cfg_pkg::*;
#(
   parameter int QUIESCE_CYCLES = 4,
   parameter int HOLD_CYCLES    = 1,
   parameter int SETTLE_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  fw_valid,
   output logic                  fw_ready,
   input  logic [CFG_ID_W-1:0]   fw_id,
   input  logic [CFG_DATA_W-1:0] fw_data,
   input  logic                  fw_last,
   output logic                  tracing,
   output logic [CFG_ID_W-1:0]   configId,
   output logic [CFG_DATA_W-1:0] configData,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CNT_W = $clog2(max3(QUIESCE_CYCLES, HOLD_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   cfg_state_t            state_reg, state_next;
   logic                  tracing_reg, tracing_next;
   logic [CFG_ID_W-1:0]   config_id_reg, config_id_next;
   logic [CFG_DATA_W-1:0] config_data_reg, config_data_next;
   logic                  done_reg, done_next;
   logic                  err_reg, err_next;
   logic                  closed_reg, closed_next;

   logic                  phase_load;
   logic [CNT_W-1:0]      phase_value;
   logic                  phase_dec;
   logic [CNT_W-1:0]      phase_count;
   logic                  hold_load;
   logic [CNT_W-1:0]      hold_count;
   logic                  hold_ending;
   logic                  handshake;

   // One phase counter serves both QUIESCE and SETTLE since they never overlap.
   cfg_down_counter #(.WIDTH(CNT_W)) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (phase_load),
      .load_value (phase_value),
      .dec        (phase_dec),
      .count      (phase_count)
   );

   cfg_down_counter #(.WIDTH(CNT_W)) u_hold_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (hold_load),
      .load_value (HOLD_LOAD),
      .dec        (1'b1),
      .count      (hold_count)
   );

   // Accepting in the last hold cycle lets back-to-back entries abut with no idle gap.
   assign hold_ending = (hold_count <= CNT_ONE);
   assign fw_ready    = (state_reg == LOAD) && !closed_reg && hold_ending;
   assign handshake   = fw_valid && fw_ready;
   assign busy        = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         tracing_reg     <= 1'b1;
         config_id_reg   <= NO_CONFIG_ID;
         config_data_reg <= '0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         closed_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         tracing_reg     <= tracing_next;
         config_id_reg   <= config_id_next;
         config_data_reg <= config_data_next;
         done_reg        <= done_next;
         err_reg         <= err_next;
         closed_reg      <= closed_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      tracing_next     = tracing_reg;
      config_id_next   = NO_CONFIG_ID;
      config_data_next = '0;
      done_next        = 1'b0;
      err_next         = err_reg;
      closed_next      = closed_reg;
      phase_load       = 1'b0;
      phase_value      = QUIESCE_LOAD;
      phase_dec        = 1'b0;
      hold_load        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = QUIESCE;
               tracing_next = 1'b0;
               err_next     = 1'b0;
               closed_next  = 1'b0;
               phase_load   = 1'b1;
               phase_value  = QUIESCE_LOAD;
            end
         end
         QUIESCE: begin
            phase_dec = 1'b1;
            if (phase_count <= CNT_ONE) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (handshake) begin
               if (fw_last) begin
                  closed_next = 1'b1;
               end
               // A reserved id is swallowed: flag it, leave the bus idle, occupy no hold slot.
               if (fw_id == NO_CONFIG_ID) begin
                  err_next = 1'b1;
               end else begin
                  config_id_next   = fw_id;
                  config_data_next = fw_data;
                  hold_load        = 1'b1;
               end
            end else if (!hold_ending) begin
               config_id_next   = config_id_reg;
               config_data_next = config_data_reg;
            end
            if (closed_reg && hold_ending) begin
               state_next  = SETTLE;
               phase_load  = 1'b1;
               phase_value = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            phase_dec = 1'b1;
            if (phase_count <= CNT_ONE) begin
               state_next   = IDLE;
               tracing_next = 1'b1;
               done_next    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign tracing    = tracing_reg;
   assign configId   = config_id_reg;
   assign configData = config_data_reg;
   assign done       = done_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (default timing and a 3-cycle hold),
// each session checked cycle by cycle against a timeline computed from the entry list.
module tb_config_loader;
   import lebug_cfg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_n [2];
   logic       start [2];
   logic       fw_valid [2];
   logic       fw_ready [2];
   logic [7:0] fw_id [2];
   logic [7:0] fw_data [2];
   logic       fw_last [2];
   logic       tracing [2];
   logic [7:0] config_id [2];
   logic [7:0] config_data [2];
   logic       busy [2];
   logic       done [2];
   logic       err [2];

   config_loader dut0 (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .fw_valid(fw_valid[0]),
      .fw_ready(fw_ready[0]), .fw_id(fw_id[0]), .fw_data(fw_data[0]), .fw_last(fw_last[0]),
      .tracing(tracing[0]), .configId(config_id[0]), .configData(config_data[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   config_loader #(.QUIESCE_CYCLES(2), .HOLD_CYCLES(3), .SETTLE_CYCLES(3)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .fw_valid(fw_valid[1]),
      .fw_ready(fw_ready[1]), .fw_id(fw_id[1]), .fw_data(fw_data[1]), .fw_last(fw_last[1]),
      .tracing(tracing[1]), .configId(config_id[1]), .configData(config_data[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   int errors = 0;
   int checks = 0;
   int q_p [2] = '{4, 2};
   int h_p [2] = '{1, 3};
   int s_p [2] = '{2, 3};
   bit err_prev [2] = '{1'b0, 1'b0};
   logic [7:0] e_id [8];
   logic [7:0] e_data [8];
   int e_gap [8];
   int last_done_cyc = -1;

   task automatic chk(input string tag, input int u, input int rel,
                      input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s unit%0d rel=%0d cycle=%0d got=%0h expected=%0h",
                tag, u, rel, cyc, obs, expv);
      end
   endtask

   task automatic reset_state_chk(input int u, input int rel);
      chk("rst_tracing", u, rel, {7'd0, tracing[u]}, 8'd1);
      chk("rst_id", u, rel, config_id[u], 8'hFF);
      chk("rst_data", u, rel, config_data[u], 8'h00);
      chk("rst_busy", u, rel, {7'd0, busy[u]}, 8'd0);
      chk("rst_done", u, rel, {7'd0, done[u]}, 8'd0);
      chk("rst_err", u, rel, {7'd0, err[u]}, 8'd0);
      chk("rst_ready", u, rel, {7'd0, fw_ready[u]}, 8'd0);
   endtask

   task automatic set_entry(input int k, input logic [7:0] id, input logic [7:0] data, input int gap);
      e_id[k]   = id;
      e_data[k] = data;
      e_gap[k]  = gap;
   endtask

   // Runs one reconfiguration; rel 0 is the cycle in which start is driven.
   task automatic session(input int u, input int n, input bit pulse_settle, input bit idle_valid);
      int q, hl, s, e, endr, total, bad_at, k;
      int h [8];
      int pres [8];
      logic [7:0] x_id [64];
      logic [7:0] x_data [64];
      bit x_rdy [64];
      bit exp_tr, exp_err;
      q = q_p[u]; hl = h_p[u]; s = s_p[u];
      bad_at = -1;
      for (int i = 0; i < n; i++) begin
         int earliest;
         if (i == 0) earliest = q + 1;
         else if (e_id[i-1] == 8'hFF) earliest = h[i-1] + 1;
         else earliest = h[i-1] + hl;
         h[i] = earliest + e_gap[i];
         if (e_gap[i] != 0) pres[i] = h[i];
         else pres[i] = (i == 0) ? 1 : h[i-1] + 1;
         if (e_id[i] == 8'hFF && bad_at < 0) bad_at = h[i];
      end
      e = (e_id[n-1] == 8'hFF) ? h[n-1] + 1 : h[n-1] + hl;
      endr = e + s + 1;
      total = endr + 3;
      for (int c = 0; c < 64; c++) begin
         x_id[c] = 8'hFF; x_data[c] = 8'h00;
         x_rdy[c] = (c >= q + 1) && (c <= h[n-1]);
      end
      for (int i = 0; i < n; i++) begin
         if (e_id[i] != 8'hFF) begin
            for (int c = h[i] + 1; c <= h[i] + hl; c++) begin
               x_id[c] = e_id[i]; x_data[c] = e_data[i];
               if (c < h[i] + hl) x_rdy[c] = 1'b0;
            end
         end
      end
      k = 0;
      exp_err = err_prev[u];
      for (int rel = 0; rel < total; rel++) begin
         @(negedge clk);
         exp_tr  = !(rel >= 1 && rel <= e + s);
         exp_err = (rel == 0) ? err_prev[u] : (bad_at >= 0 && rel > bad_at);
         chk("cfg_id", u, rel, config_id[u], x_id[rel]);
         chk("cfg_data", u, rel, config_data[u], x_data[rel]);
         chk("fw_ready", u, rel, {7'd0, fw_ready[u]}, {7'd0, x_rdy[rel]});
         chk("tracing", u, rel, {7'd0, tracing[u]}, {7'd0, exp_tr});
         chk("busy", u, rel, {7'd0, busy[u]}, {7'd0, !exp_tr});
         chk("done", u, rel, {7'd0, done[u]}, {7'd0, (rel == endr)});
         chk("err", u, rel, {7'd0, err[u]}, {7'd0, exp_err});
         if (done[u] === 1'b1) last_done_cyc = cyc;
         start[u] = (rel == 0) || (pulse_settle && rel == e + 1);
         if (k < n && rel >= pres[k]) begin
            fw_valid[u] = 1'b1; fw_id[u] = e_id[k]; fw_data[u] = e_data[k];
            fw_last[u] = (k == n - 1);
         end else if (idle_valid && (rel == 0 || rel > endr)) begin
            fw_valid[u] = 1'b1; fw_id[u] = 8'h55; fw_data[u] = 8'hAA; fw_last[u] = 1'b1;
         end else begin
            fw_valid[u] = 1'b0; fw_last[u] = 1'b0;
         end
         if (k < n && rel == h[k]) begin
            $display("unit%0d entry %0d id=%02h data=%02h last=%0d offered at cycle %0d",
                     u, k, e_id[k], e_data[k], (k == n - 1), cyc);
            k++;
         end
      end
      start[u] = 1'b0; fw_valid[u] = 1'b0; fw_last[u] = 1'b0;
      err_prev[u] = exp_err;
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; start[u] = 1'b0; fw_valid[u] = 1'b0;
         fw_id[u] = 8'h00; fw_data[u] = 8'h00; fw_last[u] = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset_state_chk(0, 0);
      reset_state_chk(1, 0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      while (cyc < 9) @(negedge clk);

      // Default timing, start at cycle 10: done expected at cycle 20.
      set_entry(0, 8'h00, 8'h03, 0);
      set_entry(1, 8'h01, 8'h02, 0);
      session(0, 2, 1'b0, 1'b0);
      chk("done_cycle", 0, 0, 8'(last_done_cyc), 8'd20);

      // 3-cycle hold, back-to-back entries offered continuously.
      set_entry(0, 8'h0A, 8'h1B, 0);
      set_entry(1, 8'h0C, 8'h2D, 0);
      session(1, 2, 1'b0, 1'b0);

      // Five-cycle valid gap between entries.
      set_entry(0, 8'h10, 8'h11, 0);
      set_entry(1, 8'h20, 8'h22, 5);
      session(0, 2, 1'b0, 1'b0);

      // Reserved id, then a normal last entry; start during SETTLE and valid in IDLE.
      set_entry(0, 8'hFF, 8'h99, 0);
      set_entry(1, 8'h02, 8'h07, 0);
      session(1, 2, 1'b1, 1'b1);
      set_entry(0, 8'h04, 8'h44, 0);
      session(1, 1, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int u, n;
         u = r % 2;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            logic [7:0] id;
            id = 8'($urandom_range(0, 254));
            if (k < n - 1 && $urandom_range(0, 7) == 0) id = 8'hFF;
            set_entry(k, id, 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
         end
         session(u, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a hold on the 3-cycle instance.
      @(negedge clk); start[1] = 1'b1;
      @(negedge clk); start[1] = 1'b0;
      fw_valid[1] = 1'b1; fw_id[1] = 8'h03; fw_data[1] = 8'h5A; fw_last[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_ready", 1, 3, {7'd0, fw_ready[1]}, 8'd1);
      @(negedge clk); fw_valid[1] = 1'b0;
      chk("mid_id", 1, 4, config_id[1], 8'h03);
      @(negedge clk);
      chk("mid_id", 1, 5, config_id[1], 8'h03);
      rst_n[1] = 1'b0;
      $display("unit1 reset asserted mid-hold at cycle %0d", cyc);
      @(negedge clk);
      reset_state_chk(1, 6);
      rst_n[1] = 1'b1;
      err_prev[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_id", 1, 7 + i, config_id[1], 8'hFF);
         chk("post_rst_busy", 1, 7 + i, {7'd0, busy[1]}, 8'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
